// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: pipelined RV32/RV64 branch/jump resolver with ROB-tag passthrough
//   Optional JAL/JALR support is compiled in when the macro BRU_JUMP_EN is defined.
//   clk, rst               clock, synchronous active-high reset
//   flush_i                kills every in-flight op; blocks acceptance that cycle
//   in_valid_i/in_ready_o  request handshake; in_instr_i, in_pc_i, in_rs1_i, in_rs2_i,
//                          in_pred_taken_i, in_pred_target_i, in_tag_i form the payload
//   out_valid_o/out_ready_i result handshake; out_tag_o, out_taken_o, out_redirect_pc_o,
//                          out_link_o, out_mispredict_o, out_misaligned_o, out_illegal_o
module branch_resolve_unit #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_instr_i,
    input  logic [XLEN-1:0]  in_pc_i,
    input  logic [XLEN-1:0]  in_rs1_i,
    input  logic [XLEN-1:0]  in_rs2_i,
    input  logic             in_pred_taken_i,
    input  logic [XLEN-1:0]  in_pred_target_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             out_taken_o,
    output logic [XLEN-1:0]  out_redirect_pc_o,
    output logic [XLEN-1:0]  out_link_o,
    output logic             out_mispredict_o,
    output logic             out_misaligned_o,
    output logic             out_illegal_o
);
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  pc, base, imm, pred_target;
        logic             taken, illegal, jalr, pred_taken;
    } dec_t;
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             taken;
        logic [XLEN-1:0]  redirect, link;
        logic             mispredict, misaligned, illegal;
    } res_t;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            cmp;
    dec_t            dec, s2_in;
    res_t            res, out_q;
    logic [XLEN-1:0] target;
    logic            adv, up_v, out_v_q;
    assign opcode = in_instr_i[6:0];
    assign funct3 = in_instr_i[14:12];
    // funct3[2:1] picks EQ / signed LT / unsigned LT; funct3[0] inverts the sense
    assign cmp = funct3[2] ? (funct3[1] ? (in_rs1_i < in_rs2_i) : ($signed(in_rs1_i) < $signed(in_rs2_i)))
                           : (in_rs1_i == in_rs2_i);
`ifndef BRU_JUMP_EN
    logic unused_bits;
    assign unused_bits = ^in_instr_i[24:15];
`endif
    always_comb begin
        dec             = '0;
        dec.tag         = in_tag_i;
        dec.pc          = in_pc_i;
        dec.base        = in_pc_i;
        dec.pred_taken  = in_pred_taken_i;
        dec.pred_target = in_pred_target_i;
        dec.imm         = {{(XLEN-13){in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                           in_instr_i[30:25], in_instr_i[11:8], 1'b0};
        dec.illegal     = 1'b1;
        if (opcode == 7'b1100011 && funct3[2:1] != 2'b01) begin
            dec.illegal = 1'b0;
            dec.taken   = cmp ^ funct3[0];
        end
`ifdef BRU_JUMP_EN
        if (opcode == 7'b1101111) begin
            dec.illegal = 1'b0;
            dec.taken   = 1'b1;
            dec.imm     = {{(XLEN-21){in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                           in_instr_i[20], in_instr_i[30:21], 1'b0};
        end
        if (opcode == 7'b1100111 && funct3 == 3'b000) begin
            dec.illegal = 1'b0;
            dec.taken   = 1'b1;
            dec.jalr    = 1'b1;
            dec.base    = in_rs1_i;
            dec.imm     = {{(XLEN-12){in_instr_i[31]}}, in_instr_i[31:20]};
        end
`endif
    end
    // JALR clears bit 0 of the sum; branches and JAL keep it
    assign target = (s2_in.base + s2_in.imm) & ~XLEN'(s2_in.jalr);
    always_comb begin
        res            = '0;
        res.tag        = s2_in.tag;
        res.taken      = s2_in.taken;
        res.illegal    = s2_in.illegal;
        res.link       = s2_in.pc + XLEN'(4);
        res.redirect   = s2_in.taken ? target : res.link;
        res.mispredict = (s2_in.taken != s2_in.pred_taken) | (s2_in.taken & (target != s2_in.pred_target));
        res.misaligned = s2_in.taken & (target[1:0] != 2'b00);
    end
    assign adv = !out_v_q | out_ready_i;
    generate
        if (LATENCY == 1) begin : g_l1
            assign in_ready_o = adv & !flush_i;
            assign up_v       = in_valid_i;
            assign s2_in      = dec;
        end else begin : g_l2
            dec_t s1_q;
            logic s1_v_q;
            assign in_ready_o = (!s1_v_q | adv) & !flush_i;
            assign up_v       = s1_v_q;
            assign s2_in      = s1_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_v_q <= 1'b0;
                    s1_q   <= '0;
                end else if (flush_i) begin
                    s1_v_q <= 1'b0;
                end else if (in_ready_o) begin
                    s1_v_q <= in_valid_i;
                    s1_q   <= dec;
                end
            end
        end
    endgenerate
    // Result data only changes when a new op moves in, so a stalled result holds
    always_ff @(posedge clk) begin
        if (rst) begin
            out_v_q <= 1'b0;
            out_q   <= '0;
        end else if (flush_i) begin
            out_v_q <= 1'b0;
        end else if (adv) begin
            out_v_q <= up_v;
            if (up_v) out_q <= res;
        end
    end
    assign out_valid_o       = out_v_q;
    assign out_tag_o         = out_q.tag;
    assign out_taken_o       = out_q.taken;
    assign out_redirect_pc_o = out_q.redirect;
    assign out_link_o        = out_q.link;
    assign out_mispredict_o  = out_q.mispredict;
    assign out_misaligned_o  = out_q.misaligned;
    assign out_illegal_o     = out_q.illegal;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: table vectors, directed stall/flush/reset sequences and a random scoreboard run
module tb_branch_resolve_unit;
    localparam int LAT = 2;
    logic clk = 0, rst, flush, in_valid, in_ready, in_pred_taken, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1, in_rs2, in_pred_target, out_redirect_pc, out_link;
    logic [3:0] in_tag, out_tag;
    logic out_taken, out_mispredict, out_misaligned, out_illegal;
    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .LATENCY(LAT), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_instr_i(in_instr), .in_pc_i(in_pc), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
        .in_pred_taken_i(in_pred_taken), .in_pred_target_i(in_pred_target), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_tag_o(out_tag), .out_taken_o(out_taken),
        .out_redirect_pc_o(out_redirect_pc), .out_link_o(out_link), .out_mispredict_o(out_mispredict),
        .out_misaligned_o(out_misaligned), .out_illegal_o(out_illegal));

    typedef struct packed {
        logic [3:0] tag; logic taken; logic [31:0] redirect, link; logic mis, misal, ill;
    } exp_t;
    typedef struct {
        string nm; logic [31:0] instr, pc, rs1, rs2; logic pt; logic [31:0] ptg;
        logic taken; logic [31:0] redir, link; logic mis, misal, ill;
    } vec_t;

    int checks = 0, failures = 0;
    bit mon_en = 0;
    exp_t sb[$];
    logic [3:0] got_tags[$];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    function automatic exp_t dut_out();
        return '{out_tag, out_taken, out_redirect_pc, out_link, out_mispredict, out_misaligned, out_illegal};
    endfunction

    // Reference: RISC-V semantics straight from the ISA rules
    function automatic exp_t model(input logic [31:0] ins, pc, rs1, rs2, input logic pt,
                                   input logic [31:0] ptg, input logic [3:0] tag);
        exp_t e; logic [31:0] tgt; bit legal = 0, tk = 0; int f3 = int'(ins[14:12]);
        tgt = 0;
        if (ins[6:0] == 7'h63) begin
            tgt = pc + {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            legal = 1;
            case (f3)
                0: tk = (rs1 == rs2);
                1: tk = (rs1 != rs2);
                4: tk = ($signed(rs1) < $signed(rs2));
                5: tk = ($signed(rs1) >= $signed(rs2));
                6: tk = (rs1 < rs2);
                7: tk = (rs1 >= rs2);
                default: legal = 0;
            endcase
        end
`ifdef BRU_JUMP_EN
        else if (ins[6:0] == 7'h6f) begin
            legal = 1; tk = 1;
            tgt = pc + {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        end else if (ins[6:0] == 7'h67 && f3 == 0) begin
            legal = 1; tk = 1;
            tgt = (rs1 + {{20{ins[31]}}, ins[31:20]}) & 32'hFFFF_FFFE;
        end
`endif
        e.tag = tag; e.taken = tk; e.link = pc + 4; e.ill = !legal;
        e.redirect = tk ? tgt : pc + 4;
        e.mis = (tk != pt) || (tk && tgt != ptg);
        e.misal = tk && (tgt % 4 != 0);
        return e;
    endfunction

    function automatic logic [31:0] b_ins(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] j_ins(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'h6f};
    endfunction
    function automatic logic [31:0] jalr_ins(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, 7'h67};
    endfunction

    // Scoreboard monitor: handshakes seen at the negedge happen on the next posedge
    bit prev_stall = 0, prev_flush = 0;
    exp_t held;
    always @(negedge clk) if (mon_en) begin
        if (rst) begin
            sb.delete(); prev_stall = 0; prev_flush = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", dut_out(), held);
            end
            if (prev_flush) chk("after_flush_out_valid", out_valid, 0);
            if (flush) chk("flush_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL extra_out: got result tag %h, required none", out_tag);
                end else begin
                    checks--;
                    chk("result", dut_out(), sb.pop_front());
                end
                got_tags.push_back(out_tag);
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready)
                sb.push_back(model(in_instr, in_pc, in_rs1, in_rs2, in_pred_taken, in_pred_target, in_tag));
            prev_stall = out_valid && !out_ready && !flush;
            prev_flush = flush;
            held = dut_out();
        end
    end

    task automatic rand_op(input logic [3:0] tag);
        exp_t e; int r = $urandom_range(0, 7);
        in_instr = $urandom;
        if (r < 5) in_instr[6:0] = 7'h63;
        else if (r == 5) in_instr[6:0] = 7'h6f;
        else if (r == 6) begin
            in_instr[6:0] = 7'h67;
            if ($urandom % 2 == 1) in_instr[14:12] = 3'b000;
        end
        in_pc = $urandom & 32'hFFFF_FFFC;
        in_rs1 = $urandom;
        in_rs2 = ($urandom % 3 == 0) ? in_rs1 : $urandom;
        in_pred_taken = $urandom % 2;
        e = model(in_instr, in_pc, in_rs1, in_rs2, 1'b1, 32'h0, tag);
        in_pred_target = ($urandom % 4 != 0) ? e.redirect : $urandom;
        in_tag = tag;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat; exp_t e;
        @(posedge clk); #1;
        in_instr = v.instr; in_pc = v.pc; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_pred_taken = v.pt; in_pred_target = v.ptg; in_tag = idx[3:0];
        in_valid = 1; out_ready = 1; flush = 0;
        @(negedge clk);
        chk({v.nm, "_accept"}, in_ready, 1);
        @(posedge clk); #1 in_valid = 0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({v.nm, "_latency"}, lat, LAT);
        e = '{idx[3:0], v.taken, v.redir, v.link, v.mis, v.misal, v.ill};
        chk(v.nm, dut_out(), e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 0; flush = 0; out_ready = 1;
        end
    endtask

    initial begin
        vec_t vt[$];
        int sent, cyc;
        bit saw_stall;
        logic [3:0] tg;
        rst = 1; flush = 0; in_valid = 1; out_ready = 1;
        rand_op(4'd9);
        repeat (3) @(posedge clk);
        #1 rst = 0; in_valid = 0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", dut_out(), 0);
        mon_en = 1;

        vt.push_back('{"beq_taken", b_ins(3'd0, 13'd8), 32'h100, 32'd5, 32'd5, 1'b1, 32'h108,
                       1'b1, 32'h108, 32'h104, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"blt_signed", b_ins(3'd4, 13'd8), 32'h100, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h108,
                       1'b1, 32'h108, 32'h104, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"bltu_unsigned", b_ins(3'd6, 13'd8), 32'h100, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h108,
                       1'b0, 32'h104, 32'h104, 1'b1, 1'b0, 1'b0});
        vt.push_back('{"bgeu_taken_mispred", b_ins(3'd7, 13'd8), 32'h100, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0,
                       1'b1, 32'h108, 32'h104, 1'b1, 1'b0, 1'b0});
        vt.push_back('{"bge_neg_imm", b_ins(3'd5, 13'h1FF0), 32'h1000, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'hFF4,
                       1'b1, 32'hFF0, 32'h1004, 1'b1, 1'b0, 1'b0});
        vt.push_back('{"bne_not_taken", b_ins(3'd1, 13'h40), 32'h200, 32'd7, 32'd7, 1'b0, 32'hDEAD,
                       1'b0, 32'h204, 32'h204, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"wrap_target", b_ins(3'd0, 13'd8), 32'hFFFF_FFFC, 32'd3, 32'd3, 1'b1, 32'h4,
                       1'b1, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"misaligned", b_ins(3'd0, 13'd6), 32'hFFFF_FFFC, 32'd3, 32'd3, 1'b1, 32'h2,
                       1'b1, 32'h2, 32'h0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{"branch_f3_010", b_ins(3'd2, 13'd8), 32'h500, 32'd1, 32'd1, 1'b0, 32'h0,
                       1'b0, 32'h504, 32'h504, 1'b0, 1'b0, 1'b1});
        vt.push_back('{"other_opcode", 32'h00B5_0533, 32'h600, 32'd1, 32'd2, 1'b1, 32'h604,
                       1'b0, 32'h604, 32'h604, 1'b1, 1'b0, 1'b1});
`ifdef BRU_JUMP_EN
        vt.push_back('{"jalr", jalr_ins(12'd0), 32'h300, 32'h201, 32'd0, 1'b1, 32'h200,
                       1'b1, 32'h200, 32'h304, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"jal", j_ins(21'h800), 32'h400, 32'd0, 32'd0, 1'b0, 32'h0,
                       1'b1, 32'hC00, 32'h404, 1'b1, 1'b0, 1'b0});
`else
        vt.push_back('{"jalr_disabled", jalr_ins(12'd0), 32'h300, 32'h201, 32'd0, 1'b1, 32'h200,
                       1'b0, 32'h304, 32'h304, 1'b1, 1'b0, 1'b1});
        vt.push_back('{"jal_disabled", j_ins(21'h800), 32'h400, 32'd0, 32'd0, 1'b0, 32'h0,
                       1'b0, 32'h404, 32'h404, 1'b0, 1'b0, 1'b1});
`endif
        foreach (vt[i]) run_vec(vt[i], i);
        idle(4);

        // Stream of 8 with a 3-cycle consumer stall
        got_tags.delete(); sent = 0; cyc = 0; saw_stall = 0;
        while ((sent < 8 || got_tags.size() < 8) && cyc < 60) begin
            @(posedge clk); #1;
            rand_op(sent[3:0]);
            in_valid = (sent < 8); flush = 0;
            out_ready = !(cyc >= 3 && cyc < 6);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (in_valid && !in_ready) saw_stall = 1;
            cyc++;
        end
        chk("stream_in_ready_dropped", saw_stall, 1);
        chk("stream_count", got_tags.size(), 8);
        foreach (got_tags[i]) chk("stream_tag_order", got_tags[i], i);
        idle(4);

        // Flush with two ops in flight plus a third on the input
        got_tags.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            rand_op(4'(10 + i));
            in_valid = 1; out_ready = 0; flush = (i == 2);
        end
        @(posedge clk); #1;
        in_valid = 0; flush = 0; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_no_out_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        rand_op(4'd13); in_valid = 1;
        @(posedge clk); #1 in_valid = 0;
        cyc = 0;
        while (got_tags.size() == 0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("post_flush_count", got_tags.size(), 1);
        chk("post_flush_tag", got_tags[0], 13);
        idle(4);

        // Reset (with flush) while ops are in flight
        got_tags.delete();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            rand_op(4'(i)); in_valid = 1; out_ready = 0;
        end
        @(posedge clk); #1;
        rst = 1; flush = 1; in_valid = 1;
        @(posedge clk); #1;
        rst = 0; flush = 0; in_valid = 0; out_ready = 1;
        @(negedge clk);
        chk("midreset_out_data", dut_out(), 0);
        for (int i = 0; i < 3; i++) begin
            chk("midreset_out_valid", out_valid, 0);
            @(negedge clk);
        end
        chk("midreset_no_results", got_tags.size(), 0);

        // Random traffic against the reference model
        tg = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rand_op(tg); tg++;
            in_valid = ($urandom % 4 != 0);
            out_ready = ($urandom % 4 != 0);
            flush = ($urandom % 64 == 0);
        end
        idle(10);
        @(negedge clk);
        chk("drain_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
